// File: rtl/addr_fifo.sv
// Synchronous address FIFO between the driver control block and the vector fetch engine.
// Registered read data one cycle after rd; sticky overrun/underrun status for the driver.
module addr_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  wr,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_val,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   input  logic [15:0]           threshold,
   output logic [15:0]           count,
   output logic                  overrun,
   output logic                  underrun,
   input  logic                  clr_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 15) begin : g_bad_depth
      $error("addr_fifo: DEPTH_LOG2 must be in 2..15");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   cnt;
   logic [DEPTH_LOG2:0]   cnt_next;
   logic                  wr_ok;
   logic                  rd_ok;

   // Status comes only from the registered count, so wr/rd never reach these outputs combinationally.
   assign empty = (cnt == '0);
   assign full  = (cnt == FULL_CNT);

   // A full FIFO still takes a write when a read frees a slot in the same edge.
   assign rd_ok = rd & ~empty;
   assign wr_ok = wr & (~full | rd_ok);

   // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_next = cnt;
      unique case ({wr_ok, rd_ok})
         2'b10:   cnt_next = cnt + (DEPTH_LOG2+1)'(1);
         2'b01:   cnt_next = cnt - (DEPTH_LOG2+1)'(1);
         default: cnt_next = cnt;
      endcase
   end

   always_comb begin
      count = '0;
      count[DEPTH_LOG2:0] = cnt;
   end

   // threshold is compared live; zero disables the flag and values above DEPTH can never be reached.
   assign almost_full = (threshold != 16'd0) && (count >= threshold);

   // NOTE: storage has no reset; stale words are unreachable because reset clears the pointers and count.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         dout     <= '0;
         dout_val <= 1'b0;
      end else begin
         cnt      <= cnt_next;
         dout_val <= rd_ok;
         if (wr_ok) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         if (rd_ok) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         end
      end
   end

   // Error flags are sticky; a new error in the same cycle as clr_err wins.
   always_ff @(posedge clk) begin
      if (!reset) begin
         overrun  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (wr & full & ~rd_ok) begin
            overrun <= 1'b1;
         end else if (clr_err) begin
            overrun <= 1'b0;
         end
         if (rd & empty) begin
            underrun <= 1'b1;
         end else if (clr_err) begin
            underrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_addr_fifo.sv
// Directed self-checking bench for addr_fifo at DEPTH=256.
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
module tb_addr_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] din;
   logic        wr;
   logic        rd;
   logic [31:0] dout;
   logic        dout_val;
   logic        empty;
   logic        full;
   logic        almost_full;
   logic [15:0] threshold;
   logic [15:0] count;
   logic        overrun;
   logic        underrun;
   logic        clr_err;

   int total = 0;
   int bad   = 0;

   addr_fifo #(.DATA_WIDTH(32), .DEPTH_LOG2(8)) dut (
      .clk(clk), .reset(reset), .din(din), .wr(wr), .rd(rd),
      .dout(dout), .dout_val(dout_val), .empty(empty), .full(full),
      .almost_full(almost_full), .threshold(threshold), .count(count),
      .overrun(overrun), .underrun(underrun), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
      din = '0; threshold = 16'd0;
      tick(); tick();
      reset = 1'b1;
      tick();

      // 1: reset then idle
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_dout_val", 32'(dout_val), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_almost_full", 32'(almost_full), 32'd0);

      // 2: fill with 0x1000..0x10FF, then one dropped write
      for (int i = 0; i < 256; i++) begin
         wr = 1'b1; din = 32'h1000 + 32'(i);
         tick();
      end
      check("fill_full", 32'(full), 32'd1);
      check("fill_count", 32'(count), 32'd256);
      check("fill_no_overrun", 32'(overrun), 32'd0);
      check("fill_af_thr0", 32'(almost_full), 32'd0);
      threshold = 16'd300;
      #1 check("af_thr_above_depth", 32'(almost_full), 32'd0);
      threshold = 16'd256;
      #1 check("af_thr_eq_depth", 32'(almost_full), 32'd1);
      threshold = 16'd0;
      din = 32'hDEAD;
      tick();
      wr = 1'b0;
      check("ovr_full", 32'(full), 32'd1);
      check("ovr_count", 32'(count), 32'd256);
      check("ovr_overrun", 32'(overrun), 32'd1);
      tick();
      check("ovr_sticky", 32'(overrun), 32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'd0);

      for (int i = 0; i < 256; i++) begin
         rd = 1'b1;
         tick();
         check("drain_dout", dout, 32'h1000 + 32'(i));
         check("drain_val", 32'(dout_val), 32'd1);
      end
      rd = 1'b0;
      tick();
      check("drain_val_low", 32'(dout_val), 32'd0);
      check("drain_hold", dout, 32'h10FF);
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_no_underrun", 32'(underrun), 32'd0);

      // 3: almost_full at threshold 4
      threshold = 16'd4;
      for (int i = 1; i <= 3; i++) begin
         wr = 1'b1; din = 32'(i);
         tick();
      end
      wr = 1'b0;
      check("af_at3", 32'(almost_full), 32'd0);
      wr = 1'b1; din = 32'd4;
      tick();
      wr = 1'b0;
      check("af_at4", 32'(almost_full), 32'd1);
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("af_after_rd", 32'(almost_full), 32'd0);
      check("af_rd_dout", dout, 32'd1);
      rd = 1'b1;
      tick(); tick(); tick();
      rd = 1'b0;
      check("af_drain_dout", dout, 32'd4);
      check("af_drain_count", 32'(count), 32'd0);
      threshold = 16'd0;

      // 4: wr and rd together on an empty FIFO
      wr = 1'b1; rd = 1'b1; din = 32'h55;
      tick();
      wr = 1'b0; rd = 1'b0;
      check("emp_wr_rd_underrun", 32'(underrun), 32'd1);
      check("emp_wr_rd_count", 32'(count), 32'd1);
      check("emp_wr_rd_val", 32'(dout_val), 32'd0);
      check("emp_wr_rd_hold", dout, 32'd4);
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("emp_next_dout", dout, 32'h55);
      check("emp_next_val", 32'(dout_val), 32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("unr_cleared", 32'(underrun), 32'd0);

      // 5: full FIFO with wr and rd together for 300 cycles, across pointer wrap
      for (int i = 0; i < 256; i++) begin
         wr = 1'b1; din = 32'h2000 + 32'(i);
         tick();
      end
      din = 32'hAA; rd = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         check("ff_dout", dout, (i < 256) ? 32'h2000 + 32'(i) : 32'hAA);
         check("ff_count", 32'(count), 32'd256);
         check("ff_overrun", 32'(overrun), 32'd0);
      end
      wr = 1'b0; rd = 1'b0;
      tick();

      // 6: reset with data stored and a read pending
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wr = 1'b1; din = 32'h300 + 32'(i);
         tick();
      end
      wr = 1'b0;
      check("pre_rst_count", 32'(count), 32'd10);
      rd = 1'b1; reset = 1'b0;
      tick();
      reset = 1'b1; rd = 1'b0;
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_empty", 32'(empty), 32'd1);
      check("mid_rst_val", 32'(dout_val), 32'd0);
      check("mid_rst_dout", dout, 32'd0);
      rd = 1'b1;
      tick();
      check("unr_set", 32'(underrun), 32'd1);
      clr_err = 1'b1;
      tick();
      check("unr_set_wins", 32'(underrun), 32'd1);
      rd = 1'b0;
      tick();
      clr_err = 1'b0;
      check("unr_clr_after", 32'(underrun), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
